// File: rtl/bram_sp_arb_if.sv
// Two-requester handshake plus single-port BRAM bus for bram_sp_arb.
// master = requesters and BRAM side, slave = the arbiter.
interface bram_sp_arb_if #(
  parameter int pAddrWidth = 11,
  parameter int pWidth     = 8
);
  logic                  Req_A;
  logic                  WE_A;
  logic [pAddrWidth-1:0] PA_A;
  logic [pWidth-1:0]     DI_A;
  logic                  Ack_A;
  logic [pWidth-1:0]     DO_A;

  logic                  Req_B;
  logic                  WE_B;
  logic [pAddrWidth-1:0] PA_B;
  logic [pWidth-1:0]     DI_B;
  logic                  Ack_B;
  logic [pWidth-1:0]     DO_B;

  logic                  Mem_CE;
  logic                  Mem_WE;
  logic [pAddrWidth-1:0] Mem_PA;
  logic [pWidth-1:0]     Mem_DI;
  logic [pWidth-1:0]     Mem_DO;
  logic                  Busy;

  modport master (
    output Req_A, WE_A, PA_A, DI_A,
    input  Ack_A, DO_A,
    output Req_B, WE_B, PA_B, DI_B,
    input  Ack_B, DO_B,
    input  Mem_CE, Mem_WE, Mem_PA, Mem_DI,
    output Mem_DO,
    input  Busy
  );

  modport slave (
    input  Req_A, WE_A, PA_A, DI_A,
    output Ack_A, DO_A,
    input  Req_B, WE_B, PA_B, DI_B,
    output Ack_B, DO_B,
    output Mem_CE, Mem_WE, Mem_PA, Mem_DI,
    input  Mem_DO,
    output Busy
  );
endinterface

// File: rtl/bram_sp_arb.sv
// Two-requester single-port BRAM arbiter: Req->Ack in 2 cycles, one access per 2 cycles, Req held until Ack.
// Ties are round-robin; define BRAM_SP_ARB_FIXED_PRI_EN to always favour A on ties.
module bram_sp_arb #(
  parameter int pAddrWidth = 11,
  parameter int pWidth     = 8
) (
  input  logic         Clk,
  input  logic         nRst,
  bram_sp_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  grant_vld;
  logic                  grant_b;
  logic                  win_b_q;
  logic                  we_q;
  logic [pAddrWidth-1:0] pa_q;
  logic [pWidth-1:0]     di_q;
  logic [pWidth-1:0]     do_a_q;
  logic [pWidth-1:0]     do_b_q;
`ifndef BRAM_SP_ARB_FIXED_PRI_EN
  logic                  last_b_q;
`endif

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // In ACK the requester just served is masked so the other one gets the next slot.
  always_comb begin
    state_d   = state_q;
    grant_vld = 1'b0;
    grant_b   = 1'b0;
    case (state_q)
      IDLE: begin
        grant_vld = bus.Req_A | bus.Req_B;
`ifdef BRAM_SP_ARB_FIXED_PRI_EN
        grant_b   = ~bus.Req_A;
`else
        grant_b   = bus.Req_B & (~bus.Req_A | ~last_b_q);
`endif
        if (grant_vld) begin
          state_d = ACC;
        end
      end
      ACC: begin
        state_d = ACK;
      end
      ACK: begin
        grant_b   = ~win_b_q;
        grant_vld = win_b_q ? bus.Req_A : bus.Req_B;
        state_d   = grant_vld ? ACC : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.Busy   = (state_q != IDLE);
    bus.Mem_CE = (state_q != IDLE);
    bus.Mem_WE = (state_q == ACC) & we_q;
    bus.Mem_PA = pa_q;
    bus.Mem_DI = di_q;
    bus.Ack_A  = (state_q == ACK) & ~win_b_q;
    bus.Ack_B  = (state_q == ACK) &  win_b_q;
    bus.DO_A   = ((state_q == ACK) && !win_b_q) ? bus.Mem_DO : do_a_q;
    bus.DO_B   = ((state_q == ACK) &&  win_b_q) ? bus.Mem_DO : do_b_q;
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      win_b_q <= 1'b0;
      we_q    <= 1'b0;
      pa_q    <= '0;
      di_q    <= '0;
      do_a_q  <= '0;
      do_b_q  <= '0;
    end else begin
      if (grant_vld) begin
        win_b_q <= grant_b;
        we_q    <= grant_b ? bus.WE_B : bus.WE_A;
        pa_q    <= grant_b ? bus.PA_B : bus.PA_A;
        di_q    <= grant_b ? bus.DI_B : bus.DI_A;
      end
      // Mem_DO is still valid on the ACK exit edge since ACK keeps CE and PA.
      if (state_q == ACK) begin
        if (win_b_q) begin
          do_b_q <= bus.Mem_DO;
        end else begin
          do_a_q <= bus.Mem_DO;
        end
      end
    end
  end

`ifndef BRAM_SP_ARB_FIXED_PRI_EN
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      last_b_q <= 1'b1;
    end else if (grant_vld) begin
      last_b_q <= grant_b;
    end
  end
`endif

endmodule

// File: tb/tb_bram_sp_arb.sv
// Bench for bram_sp_arb: directed scenarios plus random two-requester traffic
// against a shadow-memory model of a read-first BRAM with write protect.
module tb_bram_sp_arb;
  localparam int AW = 11;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bram_sp_arb_if #(.pAddrWidth(AW), .pWidth(DW)) bus ();

  bram_sp_arb #(.pAddrWidth(AW), .pWidth(DW)) dut (
    .Clk  (clk),
    .nRst (rst_n),
    .bus  (bus)
  );

  // BRAM model: 1-cycle read latency, read-first, write protect, backdoor preload
  logic [DW-1:0] bram [0:(1<<AW)-1];
  logic [DW-1:0] bram_q;
  logic          wp;
  logic          bd_we;
  logic [AW-1:0] bd_pa;
  logic [DW-1:0] bd_dat;

  always @(posedge clk) begin
    if (bd_we) begin
      bram[bd_pa] <= bd_dat;
    end else if (bus.Mem_CE) begin
      bram_q <= bram[bus.Mem_PA];
      if (bus.Mem_WE && !wp) bram[bus.Mem_PA] <= bus.Mem_DI;
    end
  end
  assign bus.Mem_DO = bus.Mem_CE ? bram_q : '0;

  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("ack_excl", bus.Ack_A & bus.Ack_B, 0);
      check("we_only_acc", bus.Mem_WE & (bus.Ack_A | bus.Ack_B | ~bus.Busy), 0);
    end
  end

  function automatic logic [DW-1:0] init_val(input int i);
    case (i)
      'h010:   return 8'h5A;
      'h020:   return 8'h77;
      'h7FF:   return 8'hE7;
      default: return 8'(i) ^ 8'hA5;
    endcase
  endfunction

  task automatic drive(input bit b, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (b) begin
      bus.Req_B = r; bus.WE_B = w; bus.PA_B = a; bus.DI_B = d;
    end else begin
      bus.Req_A = r; bus.WE_A = w; bus.PA_A = a; bus.DI_A = d;
    end
  endtask

  // One access from a single requester; lat = negedges from Req to Ack, wec = Mem_WE cycles seen.
  task automatic access(input bit b, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] dout, output int lat, output int wec);
    bit done;
    done = 1'b0; lat = 0; wec = 0; dout = '0;
    @(negedge clk);
    drive(b, 1'b1, w, a, d);
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (bus.Mem_WE) wec++;
      if (b ? bus.Ack_B : bus.Ack_A) begin
        dout = b ? bus.DO_B : bus.DO_A;
        drive(b, 1'b0, w, a, d);
        done = 1'b1;
      end
    end
    check("ack_timeout", done, 1);
    drive(b, 1'b0, w, a, d);
  endtask

  // Both requesters raise reads together and hold; acks must alternate every 2 cycles.
  task automatic tie_run(input int n, input bit first_b, input string tag);
    int cyc, last_cyc, got;
    bit exp_b;
    cyc = 0; last_cyc = 0; got = 0; exp_b = first_b;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 11'h010, 8'h00);
    drive(1, 1'b1, 1'b0, 11'h3FF, 8'h00);
    while (got < n && cyc < 4 * n + 8) begin
      @(negedge clk);
      cyc++;
      if (bus.Ack_A || bus.Ack_B) begin
        check({tag, "_who"}, bus.Ack_B, exp_b);
        check({tag, "_gap"}, cyc - last_cyc, 2);
        check({tag, "_do"}, bus.Ack_B ? bus.DO_B : bus.DO_A,
              bus.Ack_B ? shadow[11'h3FF] : shadow[11'h010]);
        last_cyc = cyc;
        exp_b = ~exp_b;
        got++;
        if (got == n) begin
          bus.Req_A = 1'b0;
          bus.Req_B = 1'b0;
        end
      end
    end
    check({tag, "_count"}, got, n);
    bus.Req_A = 1'b0;
    bus.Req_B = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, bus.Busy, 0);
  endtask

  task automatic run_random(input logic [DW-1:0] do_a0, input logic [DW-1:0] do_b0);
    logic [DW-1:0] exp_do [2];
    bit            pend [2];
    bit            fresh [2];
    bit            fast [2];
    logic          we_r [2];
    logic [AW-1:0] pa_r [2];
    logic [DW-1:0] di_r [2];
    int            lat_r [2];
    int            we_cnt, wr_acks;
    logic          ack;
    logic [DW-1:0] dov;
    logic          busy_now;
    exp_do[0] = do_a0; exp_do[1] = do_b0;
    we_cnt = 0; wr_acks = 0;
    for (int b = 0; b < 2; b++) begin
      pend[b] = 0; fast[b] = 0; fresh[b] = 0; lat_r[b] = 0;
      we_r[b] = 0; pa_r[b] = '0; di_r[b] = '0;
    end
    for (int step = 0; step < 2500; step++) begin
      @(negedge clk);
      if (bus.Mem_WE) we_cnt++;
      for (int b = 0; b < 2; b++) begin
        ack = b ? bus.Ack_B : bus.Ack_A;
        dov = b ? bus.DO_B : bus.DO_A;
        if (pend[b]) lat_r[b]++;
        if (ack) begin
          check("rnd_ack_pend", pend[b], 1);
          if (pend[b]) begin
            check("rnd_do", dov, shadow[pa_r[b]]);
            check("rnd_lat_range", (lat_r[b] >= 2 && lat_r[b] <= 5), 1);
            if (fast[b]) check("rnd_lat_idle", lat_r[b], 2);
            exp_do[b] = shadow[pa_r[b]];
            if (we_r[b]) begin
              shadow[pa_r[b]] = di_r[b];
              wr_acks++;
            end
            pend[b] = 0;
            drive(b[0], 1'b0, we_r[b], pa_r[b], di_r[b]);
          end
        end else begin
          check("rnd_do_hold", dov, exp_do[b]);
          if (pend[b]) begin
            check("rnd_wait", lat_r[b] <= 4, 1);
            if (lat_r[b] > 8) begin
              pend[b] = 0;
              drive(b[0], 1'b0, we_r[b], pa_r[b], di_r[b]);
            end
          end
        end
      end
      busy_now = bus.Busy;
      for (int b = 0; b < 2; b++) begin
        fresh[b] = 0;
        if (step < 2400 && !pend[b] && $urandom_range(0, 2) == 0) begin
          we_r[b]  = 1'($urandom_range(0, 1));
          pa_r[b]  = 11'($urandom_range(0, 15));
          di_r[b]  = 8'($urandom);
          lat_r[b] = 0;
          pend[b]  = 1;
          fresh[b] = 1;
          drive(b[0], 1'b1, we_r[b], pa_r[b], di_r[b]);
        end
      end
      for (int b = 0; b < 2; b++) begin
        if (fresh[b]) fast[b] = !busy_now && !(b ? bus.Req_A : bus.Req_B);
      end
    end
    check("rnd_drained", pend[0] | pend[1], 0);
    check("rnd_we_cycles", we_cnt, wr_acks);
  endtask

  initial begin
    logic [DW-1:0] dout;
    int            lat, wec;
    rst_n = 1'b0; wp = 1'b0; bd_we = 1'b0; bd_pa = '0; bd_dat = '0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    #1;
    check("rst_busy", bus.Busy, 0);
    check("rst_ack", {bus.Ack_A, bus.Ack_B}, 0);
    check("rst_ce_we", {bus.Mem_CE, bus.Mem_WE}, 0);
    check("rst_pa", bus.Mem_PA, 0);
    check("rst_di", bus.Mem_DI, 0);
    check("rst_do", {bus.DO_A, bus.DO_B}, 0);

    for (int i = 0; i < (1 << AW); i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_pa = 11'(i); bd_dat = init_val(i);
      shadow[i] = init_val(i);
    end
    @(negedge clk);
    bd_we = 1'b0;
    check("rst_hold_busy", bus.Busy, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single read by A
    access(0, 1'b0, 11'h010, 8'h00, dout, lat, wec);
    check("r20_lat", lat, 2);
    check("r20_do", dout, 8'h5A);
    @(negedge clk);
    check("r20_ack_pulse", bus.Ack_A, 0);
    check("r20_do_hold", bus.DO_A, 8'h5A);
    check("r20_idle_ce", {bus.Mem_CE, bus.Mem_WE, bus.Busy}, 0);
    check("r20_pa_hold", bus.Mem_PA, 11'h010);
    @(negedge clk);
    check("r20_do_hold2", bus.DO_A, 8'h5A);

    // Write then read by B; write returns the pre-write contents
    access(1, 1'b1, 11'h3FF, 8'hC3, dout, lat, wec);
    check("r21_wr_lat", lat, 2);
    check("r21_we_cycles", wec, 1);
    check("r21_wr_do", dout, shadow[11'h3FF]);
    shadow[11'h3FF] = 8'hC3;
    access(1, 1'b0, 11'h3FF, 8'h00, dout, lat, wec);
    check("r21_rd_do", dout, 8'hC3);
    check("r21_rd_we", wec, 0);
    @(negedge clk);
    check("r21_do_b_hold", bus.DO_B, 8'hC3);
    check("r21_do_a_kept", bus.DO_A, 8'h5A);

    // Ties: last grant was B so A goes first; afterwards last grant is A
    tie_run(5, 1'b0, "tie1");
`ifdef BRAM_SP_ARB_FIXED_PRI_EN
    tie_run(4, 1'b0, "tie2");
`else
    tie_run(4, 1'b1, "tie2");
`endif

    // Write-protected write completes but leaves memory unchanged
    wp = 1'b1;
    access(0, 1'b1, 11'h7FF, 8'h11, dout, lat, wec);
    check("r25_lat", lat, 2);
    check("r25_we_cycles", wec, 1);
    wp = 1'b0;
    access(0, 1'b0, 11'h7FF, 8'h00, dout, lat, wec);
    check("r25_rd_do", dout, 8'hE7);

    // Reset in the middle of a write's ACC cycle
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 11'h020, 8'h99);
    @(negedge clk);
    check("r24_we_acc", bus.Mem_WE, 1);
    check("r24_pa_acc", bus.Mem_PA, 11'h020);
    #1 rst_n = 1'b0;
    #1;
    check("r24_we_drop", bus.Mem_WE, 0);
    check("r24_busy", bus.Busy, 0);
    check("r24_ack", {bus.Ack_A, bus.Ack_B}, 0);
    check("r24_do", {bus.DO_A, bus.DO_B}, 0);
    check("r24_pa_di", {bus.Mem_PA, bus.Mem_DI}, 0);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("r24_no_ack", {bus.Ack_A, bus.Ack_B, bus.Busy}, 0);
    end
    access(0, 1'b0, 11'h020, 8'h00, dout, lat, wec);
    check("r17_first_lat", lat, 2);
    check("r24_not_written", dout, 8'h77);

    run_random(8'h77, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
